alu_share_ctrl: RTL and testbench

- Arbitration and sequencing controller that shares the single combinational 16-bit ALU between two requesters, e.g. the execute stage and an address/increment unit.
- Accepts operations over valid/ready handshakes and grants them round-robin.
- Drives the ALU operand and function inputs from registers, captures valE, and returns each result on a per-requester response channel.
- Owns the architectural condition-code register (ZF, SF, OF), so the ALU needs no flag-holding feedback.

---
 rtl/alu_share_ctrl.sv | 151 +++++++++++++++
 tb/tb_alu_share_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one combinational ALU between two requesters.
// Requests are granted round-robin from IDLE. The operation is held on alu_*
// for one ISSUE cycle, and the result is then returned on the owner's response
// channel. This block holds the ZF/SF/OF condition codes.
module alu_share_ctrl #(
    parameter int WIDTH = 16,
    parameter int FUN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [FUN_W-1:0] req0_fun,
    input  logic             req0_setcc,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_data,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [FUN_W-1:0] req1_fun,
    input  logic             req1_setcc,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_data,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [FUN_W-1:0] alu_fun,
    input  logic [WIDTH-1:0] alu_valE,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [FUN_W-1:0] FUN_ADD = FUN_W'(0);
    localparam logic [FUN_W-1:0] FUN_SUB = FUN_W'(1);

    state_t state;
    logic   lastGrant;
    logic   owner;
    logic   opSetcc;
    logic   anyReq;
    logic   grantSel;
    logic   rspTaken;

    // Two's-complement overflow of the issued operation. Only add and sub can
    // overflow. Logic ops and unknown codes report no overflow.
    function automatic logic calcOverflow(
        input logic [FUN_W-1:0]        fun,
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b,
        input logic signed [WIDTH-1:0] res
    );
        logic aNeg;
        logic bNeg;
        logic rNeg;
        aNeg = a[WIDTH-1];
        bNeg = b[WIDTH-1];
        rNeg = res[WIDTH-1];
        if (fun == FUN_ADD) begin
            return (aNeg == bNeg) && (rNeg != aNeg);
        end else if (fun == FUN_SUB) begin
            return (aNeg != bNeg) && (rNeg != aNeg);
        end else begin
            return 1'b0;
        end
    endfunction

    // Round-robin grant: a lone requester wins. On contention, the requester
    // that was not served last wins.
    always_comb begin
        anyReq   = req0_valid || req1_valid;
        grantSel = (req0_valid && req1_valid) ? ~lastGrant : req1_valid;
        rspTaken = owner ? rsp1_ready : rsp0_ready;
    end

    assign req0_ready = (state == IDLE) && !rst && anyReq && !grantSel;
    assign req1_ready = (state == IDLE) && !rst && anyReq && grantSel;
    assign busy       = (state != IDLE);

    // Sequencer: accept in IDLE, capture the ALU result in ISSUE, and hold the response in RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            lastGrant  <= 1'b1;
            owner      <= 1'b0;
            opSetcc    <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_fun    <= '0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
            cc_zf      <= 1'b0;
            cc_sf      <= 1'b0;
            cc_of      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        owner   <= grantSel;
                        alu_a   <= grantSel ? req1_a : req0_a;
                        alu_b   <= grantSel ? req1_b : req0_b;
                        alu_fun <= grantSel ? req1_fun : req0_fun;
                        opSetcc <= grantSel ? req1_setcc : req0_setcc;
                        state   <= ISSUE;
                    end
                end
                // ---- ISSUE -> RESP: operands have settled through the ALU ----
                ISSUE: begin
                    if (owner) begin
                        rsp1_data  <= alu_valE;
                        rsp1_valid <= 1'b1;
                    end else begin
                        rsp0_data  <= alu_valE;
                        rsp0_valid <= 1'b1;
                    end
                    if (opSetcc) begin
                        cc_zf <= (alu_valE == '0);
                        cc_sf <= alu_valE[WIDTH-1];
                        cc_of <= calcOverflow(alu_fun, alu_a, alu_b, alu_valE);
                    end
                    state <= RESP;
                end
                RESP: begin
                    if (rspTaken) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        lastGrant  <= owner;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: table-driven vectors for single operations, plus
// sequences for contention, backpressure and reset during an operation.
module tb_alu_share_ctrl;

    localparam int WIDTH = 16;
    localparam int FUN_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req0_valid = 1'b0, req1_valid = 1'b0;
    logic             req0_ready, req1_ready;
    logic [WIDTH-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [FUN_W-1:0] req0_fun = '0, req1_fun = '0;
    logic             req0_setcc = 1'b0, req1_setcc = 1'b0;
    logic             rsp0_valid, rsp1_valid;
    logic             rsp0_ready = 1'b1, rsp1_ready = 1'b1;
    logic [WIDTH-1:0] rsp0_data, rsp1_data;
    logic [WIDTH-1:0] alu_a, alu_b, alu_valE;
    logic [FUN_W-1:0] alu_fun;
    logic             cc_zf, cc_sf, cc_of, busy;

    int nVec  = 0;
    int nFail = 0;

    always #5 clk = ~clk;

    alu_share_ctrl #(.WIDTH(WIDTH), .FUN_W(FUN_W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
        .req0_fun(req0_fun), .req0_setcc(req0_setcc),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
        .req1_fun(req1_fun), .req1_setcc(req1_setcc),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_valE(alu_valE),
        .cc_zf(cc_zf), .cc_sf(cc_sf), .cc_of(cc_of), .busy(busy)
    );

    // Combinational ALU attached to the controller. An unknown code returns ~a.
    always_comb begin
        case (alu_fun)
            4'd0:    alu_valE = alu_a + alu_b;
            4'd1:    alu_valE = alu_a - alu_b;
            4'd2:    alu_valE = alu_a & alu_b;
            4'd3:    alu_valE = alu_a ^ alu_b;
            default: alu_valE = ~alu_a;
        endcase
    end

    typedef struct {
        logic        who;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  fun;
        logic        setcc;
        logic [15:0] expData;
        logic        zf;
        logic        sf;
        logic        of;
        int          stall;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic driveReq(input logic who, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] fun, input logic setcc);
        if (who) begin
            req1_valid = 1'b1; req1_a = a; req1_b = b; req1_fun = fun; req1_setcc = setcc;
        end else begin
            req0_valid = 1'b1; req0_a = a; req0_b = b; req0_fun = fun; req0_setcc = setcc;
        end
    endtask

    task automatic runOp(input vec_t v);
        int   cnt;
        logic rdy;
        @(negedge clk);
        driveReq(v.who, v.a, v.b, v.fun, v.setcc);
        if (v.who) rsp1_ready = (v.stall == 0); else rsp0_ready = (v.stall == 0);
        #1;
        cnt = 0;
        rdy = v.who ? req1_ready : req0_ready;
        while (!rdy && cnt < 20) begin
            @(negedge clk); #1;
            cnt++;
            rdy = v.who ? req1_ready : req0_ready;
        end
        check("accept_timeout", 32'(cnt < 20), 32'd1);
        @(posedge clk);
        @(negedge clk);
        // Scramble requester inputs after acceptance; they must have no effect.
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = 16'($urandom); req0_b = 16'($urandom);
        req1_a = 16'($urandom); req1_b = 16'($urandom);
        #1;
        check("issue_busy", 32'(busy), 32'd1);
        check("issue_rsp_early", 32'(v.who ? rsp1_valid : rsp0_valid), 32'd0);
        @(negedge clk); #1;
        check("resp_valid", 32'(v.who ? rsp1_valid : rsp0_valid), 32'd1);
        check("resp_other_valid", 32'(v.who ? rsp0_valid : rsp1_valid), 32'd0);
        check("resp_data", 32'(v.who ? rsp1_data : rsp0_data), 32'(v.expData));
        check("alu_a_hold", 32'(alu_a), 32'(v.a));
        check("cc_zf", 32'(cc_zf), 32'(v.zf));
        check("cc_sf", 32'(cc_sf), 32'(v.sf));
        check("cc_of", 32'(cc_of), 32'(v.of));
        for (int s = 0; s < v.stall; s++) begin
            @(negedge clk); #1;
            check("stall_valid", 32'(v.who ? rsp1_valid : rsp0_valid), 32'd1);
            check("stall_data", 32'(v.who ? rsp1_data : rsp0_data), 32'(v.expData));
        end
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        check("resp_drop", 32'(v.who ? rsp1_valid : rsp0_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk); #1;
        check("rst_ready0", 32'(req0_ready), 32'd0);
        check("rst_ready1", 32'(req1_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rsp_valid", 32'({rsp0_valid, rsp1_valid}), 32'd0);
        check("rst_rsp_data", 32'({rsp0_data, rsp1_data}), 32'd0);
        check("rst_cc", 32'({cc_zf, cc_sf, cc_of}), 32'd0);
        check("rst_alu", 32'({alu_a, alu_b, alu_fun}), 32'd0);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int grants[$];
        int nRsp0;
        int nRsp1;

        //          who   a         b         fun   cc    data      zf    sf    of    stall
        vecs[0] = '{1'b0, 16'h7FFF, 16'h0001, 4'd0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 0};
        vecs[1] = '{1'b0, 16'h0001, 16'h0001, 4'd0, 1'b0, 16'h0002, 1'b0, 1'b1, 1'b1, 1};
        vecs[2] = '{1'b0, 16'h8000, 16'h0001, 4'd1, 1'b1, 16'h7FFF, 1'b0, 1'b0, 1'b1, 2};
        vecs[3] = '{1'b1, 16'h1234, 16'h00FF, 4'd2, 1'b1, 16'h0034, 1'b0, 1'b0, 1'b0, 0};
        vecs[4] = '{1'b1, 16'h0005, 16'h0005, 4'd1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1};
        vecs[5] = '{1'b0, 16'h00FF, 16'h0F0F, 4'd3, 1'b1, 16'h0FF0, 1'b0, 1'b0, 1'b0, 2};
        vecs[6] = '{1'b1, 16'h7000, 16'h7000, 4'd7, 1'b1, 16'h8FFF, 1'b0, 1'b1, 1'b0, 0};
        vecs[7] = '{1'b0, 16'h7FFF, 16'hFFFF, 4'd1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b1, 1};

        doReset();
        for (int i = 0; i < 8; i++) begin
            runOp(vecs[i]);
        end

        // Contention: both requesters stay valid, so grants must alternate starting with 0.
        doReset();
        @(negedge clk);
        driveReq(1'b0, 16'h0005, 16'h0005, 4'd1, 1'b1);
        driveReq(1'b1, 16'h00FF, 16'h0F0F, 4'd3, 1'b0);
        nRsp0 = 0; nRsp1 = 0;
        for (int cyc = 0; cyc < 40 && grants.size() < 4; cyc++) begin
            if (cyc > 0) @(negedge clk);
            #1;
            if (req0_ready && req1_ready) check("cont_both_ready", 32'd1, 32'd0);
            if (req0_ready) grants.push_back(0);
            else if (req1_ready) grants.push_back(1);
            if (rsp0_valid) begin
                nRsp0++;
                check("cont_rsp0_data", 32'(rsp0_data), 32'h0000);
                check("cont_rsp0_cc", 32'({cc_zf, cc_sf, cc_of}), 32'b100);
            end
            if (rsp1_valid) begin
                nRsp1++;
                check("cont_rsp1_data", 32'(rsp1_data), 32'h0FF0);
                check("cont_rsp1_cc", 32'({cc_zf, cc_sf, cc_of}), 32'b100);
            end
        end
        check("cont_grant_count", 32'(grants.size()), 32'd4);
        for (int i = 0; i < grants.size(); i++) begin
            check("cont_grant_order", 32'(grants[i]), 32'(i % 2));
        end
        check("cont_rsp_seen", 32'((nRsp0 > 0) && (nRsp1 > 0)), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        check("cont_last_rsp1", 32'(rsp1_valid), 32'd1);
        check("cont_last_data", 32'(rsp1_data), 32'h0FF0);
        check("cont_final_cc", 32'({cc_zf, cc_sf, cc_of}), 32'b100);
        @(negedge clk);

        // Backpressure on requester 1 while requester 0 waits.
        @(negedge clk);
        rsp1_ready = 1'b0;
        driveReq(1'b1, 16'h1234, 16'h00FF, 4'd2, 1'b1);
        #1;
        check("bp_accept", 32'(req1_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        driveReq(1'b0, 16'h0003, 16'h0004, 4'd0, 1'b0);
        #1;
        check("bp_issue_ready0", 32'(req0_ready), 32'd0);
        for (int s = 0; s < 5; s++) begin
            @(negedge clk); #1;
            check("bp_valid", 32'(rsp1_valid), 32'd1);
            check("bp_data", 32'(rsp1_data), 32'h0034);
            check("bp_ready0", 32'(req0_ready), 32'd0);
        end
        rsp1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk); #1;
        check("bp_done_valid", 32'(rsp1_valid), 32'd0);
        check("bp_next_grant", 32'(req0_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk); #1;
        check("bp_rsp0_data", 32'(rsp0_valid ? rsp0_data : 16'hDEAD), 32'h0007);
        @(negedge clk);

        // Reset while requester 1 sits in RESP with flags set.
        @(negedge clk);
        rsp1_ready = 1'b0;
        driveReq(1'b1, 16'h7FFF, 16'h0001, 4'd0, 1'b1);
        #1;
        check("rm_accept", 32'(req1_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk); #1;
        check("rm_resp_valid", 32'(rsp1_valid), 32'd1);
        check("rm_cc_before", 32'({cc_zf, cc_sf, cc_of}), 32'b011);
        rst = 1'b1;
        driveReq(1'b0, 16'h0010, 16'h0001, 4'd1, 1'b0);
        driveReq(1'b1, 16'h0002, 16'h0002, 4'd0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rm_rsp1_cleared", 32'(rsp1_valid), 32'd0);
        check("rm_cc_cleared", 32'({cc_zf, cc_sf, cc_of}), 32'd0);
        check("rm_busy", 32'(busy), 32'd0);
        check("rm_grant0", 32'({req0_ready, req1_ready}), 32'b10);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk); #1;
        check("rm_rsp0_valid", 32'(rsp0_valid), 32'd1);
        check("rm_rsp0_data", 32'(rsp0_data), 32'h000F);
        check("rm_rsp1_quiet", 32'(rsp1_valid), 32'd0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
